mem_responder: RTL and testbench

Memory-side responder for the 32-bit MIPS core's memory port (memread/memwrite/adr/writedata/memdata). It replaces the zero-latency behavioural memory with a synthesizable word-addressed store. The store has a programmable number of wait states, a ready handshake, and error reporting. It sits in the devices subsystem between the core and the on-chip SRAM array, and lets the core and bench exercise multi-cycle memory timing.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_array.sv | 29 ++
 rtl/mem_responder.sv | 181 ++++++++++++++++++
 tb/tb_mem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder and its storage array.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte address bits below this position select a byte within a word.
  localparam int ADR_LSB = 2;

  // Word index of a byte address. Kept at 64 bits so the caller can both
  // index the array with the low bits and range-check the upper bits.
  function automatic logic [63:0] word_index(input logic [63:0] adr);
    return adr >> ADR_LSB;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word store: synchronous write, synchronous (registered) read.
// Latency: write visible and read data valid one clock after we/re.
// Backpressure: none; accepts an access every cycle.
// Ports: clk; we/re enables; addr word index; wdata in; rdata registered out.
// The storage is deliberately not reset so contents survive a core reset.
module mem_array #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MIPS core port with programmable wait states.
// Latency: request accepted in IDLE at edge E0 -> ready pulse in the cycle after edge E0+WAIT_CYCLES.
// Backpressure: requests are ignored outside IDLE; back-to-back spacing is WAIT_CYCLES+2 cycles.
// Ports: clk, reset (sync, active-high); memread/memwrite/adr/writedata request;
//        memdata read data (held until next read), ready one-cycle completion, err with ready.
// Optional: define MEM_STATS_EN to add saturating rd_count/wr_count outputs.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] memdata,
  output logic             ready,
  output logic             err
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]      rd_count,
  output logic [31:0]      wr_count
`endif
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [WIDTH-1:0]  adr_q, adr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  memdata_q, memdata_d;

  logic              in_idle;
  logic              eff_rd, eff_wr;
  logic [WIDTH-1:0]  eff_adr, eff_wdata;
  logic [63:0]       eff_idx;
  logic              eff_bad;
  logic              go_resp;
  logic              arr_we, arr_re;
  logic [WIDTH-1:0]  arr_rdata;
  logic [WIDTH-1:0]  rd_result;

  // In IDLE the live request is the transaction (needed when WAIT_CYCLES=0,
  // where the array is accessed on the accepting edge); elsewhere the latched
  // copy is used so the requester may change its inputs freely.
  // Write takes priority when both memread and memwrite are set.
  assign in_idle   = (state_q == IDLE);
  assign eff_wr    = in_idle ? memwrite : wr_q;
  assign eff_rd    = in_idle ? (memread & ~memwrite) : rd_q;
  assign eff_adr   = in_idle ? adr : adr_q;
  assign eff_wdata = in_idle ? writedata : wdata_q;

  // Upper word-index bits only feed the range check, never the array index,
  // so an out-of-range address cannot alias onto a real word.
  assign eff_idx = word_index(64'(eff_adr));
  assign eff_bad = (|eff_adr[ADR_LSB-1:0]) | (|eff_idx[63:DEPTH_LOG2]);

  // The array is accessed on the edge entering RESP; reset on that same edge
  // aborts the transaction, so an uncommitted write never lands.
  assign arr_we = go_resp & eff_wr & ~eff_bad & ~reset;
  assign arr_re = go_resp & eff_rd & ~eff_bad & ~reset;

  mem_array #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (eff_idx[DEPTH_LOG2-1:0]),
    .wdata (eff_wdata),
    .rdata (arr_rdata)
  );

  assign rd_result = eff_bad ? '0 : arr_rdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    memdata_d = memdata_q;
    go_resp   = 1'b0;
    case (state_q)
      IDLE: begin
        if (memread | memwrite) begin
          rd_d    = eff_rd;
          wr_d    = eff_wr;
          adr_d   = adr;
          wdata_d = writedata;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        // Capture the completed read so memdata holds after the pulse.
        if (rd_q) begin
          memdata_d = rd_result;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      adr_q     <= '0;
      wdata_q   <= '0;
      memdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      memdata_q <= memdata_d;
    end
  end

  // During RESP the fresh array output is forwarded so new read data is
  // visible together with ready; afterwards the captured copy is shown.
  assign ready   = (state_q == RESP);
  assign err     = ready & eff_bad;
  assign memdata = (ready && rd_q) ? rd_result : memdata_q;

`ifdef MEM_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (ready && !eff_bad) begin
      if (rd_q && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_d = rd_cnt_q + 32'd1;
      if (wr_q && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with default wait states, one with zero.
// Directed scenarios followed by randomized traffic checked against an array model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_rd, a_wr, b_rd, b_wr;
  logic [31:0] a_adr, a_wd, b_adr, b_wd;
  logic [31:0] a_md, b_md;
  logic        a_rdy, a_err, b_rdy, b_err;
`ifdef MEM_STATS_EN
  logic [31:0] a_rdc, a_wrc, b_rdc, b_wrc;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: word store, last read value, good-completion counts.
  logic [31:0] mdl_mem [2][256];
  logic [31:0] mdl_md  [2];
  int          mdl_rdn [2];
  int          mdl_wrn [2];
  int          wc      [2] = '{2, 0};

  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .reset(reset), .memread(a_rd), .memwrite(a_wr), .adr(a_adr),
    .writedata(a_wd), .memdata(a_md), .ready(a_rdy), .err(a_err)
`ifdef MEM_STATS_EN
    , .rd_count(a_rdc), .wr_count(a_wrc)
`endif
  );

  mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .memread(b_rd), .memwrite(b_wr), .adr(b_adr),
    .writedata(b_wd), .memdata(b_md), .ready(b_rdy), .err(b_err)
`ifdef MEM_STATS_EN
    , .rd_count(b_rdc), .wr_count(b_wrc)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (s == 0) begin a_rd = rd; a_wr = wr; a_adr = a; a_wd = d; end
    else        begin b_rd = rd; b_wr = wr; b_adr = a; b_wd = d; end
  endtask

  function automatic logic get_rdy(input int s);
    return (s == 0) ? a_rdy : b_rdy;
  endfunction
  function automatic logic get_err(input int s);
    return (s == 0) ? a_err : b_err;
  endfunction
  function automatic logic [31:0] get_md(input int s);
    return (s == 0) ? a_md : b_md;
  endfunction
  function automatic logic [31:0] arr_word(input int s, input logic [7:0] i);
    return (s == 0) ? dut.u_array.mem[i] : dut0.u_array.mem[i];
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      mdl_md[s] = '0; mdl_rdn[s] = 0; mdl_wrn[s] = 0;
    end
  endtask

  task automatic chk_stats(input string tag);
`ifdef MEM_STATS_EN
    chk({tag, "_rd_a"}, a_rdc, mdl_rdn[0]);
    chk({tag, "_wr_a"}, a_wrc, mdl_wrn[0]);
    chk({tag, "_rd_b"}, b_rdc, mdl_rdn[1]);
    chk({tag, "_wr_b"}, b_wrc, mdl_wrn[1]);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // One complete transaction: drive at a negedge while idle, scramble the
  // inputs after acceptance, then check timing, status, data and array.
  task automatic txn(input int s, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int n;
    bit got, bad, is_rd, is_wr;
    logic [31:0] idx;
    is_wr = wr;
    is_rd = rd && !wr;
    idx   = a >> 2;
    bad   = (a[1:0] != 2'b00) || (idx >= 256);
    if (is_wr && !bad) mdl_mem[s][idx[7:0]] = d;
    if (is_rd) mdl_md[s] = bad ? 32'h0 : mdl_mem[s][idx[7:0]];
    if (!bad && is_rd) mdl_rdn[s]++;
    if (!bad && is_wr) mdl_wrn[s]++;
    drive(s, rd, wr, a, d);
    n = 0;
    got = 0;
    while (!got && n < 16) begin
      @(negedge clk);
      n++;
      if (n == 1) drive(s, 1'b0, 1'b0, $urandom, $urandom);
      got = get_rdy(s);
    end
    chk("latency", n, wc[s] + 1);
    chk("err", get_err(s), bad);
    chk("memdata", get_md(s), mdl_md[s]);
    if (idx < 256) chk("array_word", arr_word(s, idx[7:0]), mdl_mem[s][idx[7:0]]);
    @(negedge clk);
    chk("ready_pulse", get_rdy(s), 1'b0);
    chk("memdata_hold", get_md(s), mdl_md[s]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    model_reset();
    chk("rst_memdata_a", a_md, 32'h0);
    chk("rst_ready_a", a_rdy, 1'b0);
    chk("rst_err_a", a_err, 1'b0);
    chk("rst_memdata_b", b_md, 32'h0);
    chk("rst_ready_b", b_rdy, 1'b0);
    chk("rst_err_b", b_err, 1'b0);
    chk_stats("rst_stats");
    reset = 1'b0;
  endtask

  initial begin
    int sel, op, pick;
    logic [31:0] a, w7;

    do_reset();

    // Preload every word of both instances through the port.
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) txn(s, 1'b0, 1'b1, i * 4, $urandom);

    // Write then read back.
    txn(0, 1'b0, 1'b1, 32'd20, 32'd7);
    chk("word5_is_7", arr_word(0, 8'd5), 32'd7);
    txn(0, 1'b1, 1'b0, 32'd20, 32'd0);
    chk("readback_7", a_md, 32'd7);

    // Error cases and the last valid word.
    txn(0, 1'b0, 1'b1, 32'd21, 32'd9);
    chk("word5_kept", arr_word(0, 8'd5), 32'd7);
    txn(0, 1'b1, 1'b0, 32'd1024, 32'd0);
    chk("oor_read_zero", a_md, 32'd0);
    txn(0, 1'b1, 1'b0, 32'd1020, 32'd0);
    txn(0, 1'b1, 1'b0, 32'h0001_0014, 32'd0);

    // Simultaneous read and write behaves as a write.
    txn(0, 1'b1, 1'b1, 32'd24, 32'hA5);
    chk("word6_a5", arr_word(0, 8'd6), 32'hA5);

    // Zero wait states, request held continuously: ready every other cycle.
    drive(1, 1'b1, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("b2b_rdy1", b_rdy, 1'b1);
    chk("b2b_md0", b_md, mdl_mem[1][0]);
    b_adr = 32'd4;
    @(negedge clk);
    chk("b2b_gap", b_rdy, 1'b0);
    chk("b2b_md0_hold", b_md, mdl_mem[1][0]);
    @(negedge clk);
    chk("b2b_rdy2", b_rdy, 1'b1);
    chk("b2b_md1", b_md, mdl_mem[1][1]);
    b_rd = 1'b0;
    mdl_md[1] = mdl_mem[1][1];
    mdl_rdn[1] += 2;
    @(negedge clk);
    chk("b2b_end", b_rdy, 1'b0);

    // Reset during the first wait cycle aborts the write.
    w7 = mdl_mem[0][7];
    drive(0, 1'b0, 1'b1, 32'd28, 32'h55);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, '0, '0);
    chk("midwait_rdy", a_rdy, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    chk("midrst_rdy", a_rdy, 1'b0);
    chk("midrst_err", a_err, 1'b0);
    chk("midrst_md_a", a_md, 32'h0);
    chk("midrst_md_b", b_md, 32'h0);
    chk("word7_kept", arr_word(0, 8'd7), w7);
    chk_stats("midrst_stats");
    reset = 1'b0;
    txn(0, 1'b1, 1'b0, 32'd28, 32'd0);
    chk("word7_read_old", a_md, w7);

    // Statistics scenario from a clean reset.
    do_reset();
    txn(0, 1'b1, 1'b0, 32'd0, 32'd0);
    txn(0, 1'b1, 1'b0, 32'd8, 32'd0);
    txn(0, 1'b1, 1'b0, 32'd12, 32'd0);
    txn(0, 1'b0, 1'b1, 32'd16, 32'h1234);
    txn(0, 1'b0, 1'b1, 32'd32, 32'h5678);
    txn(0, 1'b1, 1'b0, 32'd2, 32'd0);
`ifdef MEM_STATS_EN
    chk("stats_rd3", a_rdc, 32'd3);
    chk("stats_wr2", a_wrc, 32'd2);
`endif

    // Randomized traffic on both instances.
    for (int k = 0; k < 300; k++) begin
      sel  = $urandom_range(0, 1);
      op   = $urandom_range(1, 3);
      pick = $urandom_range(0, 9);
      if (pick < 7)      a = $urandom_range(0, 255) * 4;
      else if (pick < 8) a = $urandom_range(0, 255) * 4 + $urandom_range(1, 3);
      else               a = ($urandom | 32'h400) & 32'hFFFF_FFFC;
      txn(sel, op[0], op[1], a, $urandom);
    end
    chk_stats("final_stats");

    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
